// File: rtl/fft_spectrum_stream_pkg.sv
// Shared constants and FSM encoding for the FFT spectrum streaming controller.
`timescale 1ns/1ps
`default_nettype none

package fft_spectrum_stream_pkg;

    localparam int FFT_WORD_SIZE   = 16;
    localparam int FFT_LOG2_POINTS = 12;
    localparam int FFT_EXP_WIDTH   = 6;
    localparam int FFT_EXT_BITS    = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/fft_spectrum_stream_if.sv
// Bundle of sample, core sink/source and magnitude output handshakes.
`timescale 1ns/1ps
`default_nettype none

interface fft_spectrum_stream_if
    import fft_spectrum_stream_pkg::*;
#(
    parameter int WORD_SIZE   = FFT_WORD_SIZE,
    parameter int LOG2_POINTS = FFT_LOG2_POINTS,
    parameter int EXP_WIDTH   = FFT_EXP_WIDTH
) ();

    logic                   inValid;
    logic [WORD_SIZE-1:0]   inData;
    logic                   inReady;

    logic                   coreSinkValid;
    logic                   coreSinkSop;
    logic                   coreSinkEop;
    logic [WORD_SIZE-1:0]   coreSinkReal;
    logic [WORD_SIZE-1:0]   coreSinkImag;
    logic                   coreSinkReady;

    logic                   coreSourceValid;
    logic                   coreSourceSop;
    logic                   coreSourceEop;
    logic [WORD_SIZE-1:0]   coreSourceReal;
    logic [WORD_SIZE-1:0]   coreSourceImag;
    logic [EXP_WIDTH-1:0]   coreSourceExp;
    logic                   coreSourceReady;

    logic [4:0]             gainShift;

    logic                   outValid;
    logic                   outReady;
    logic [WORD_SIZE-1:0]   outData;
    logic [LOG2_POINTS-1:0] outBin;
    logic                   outSop;
    logic                   outEop;
    logic                   satFlag;
    logic                   frameError;

    modport slave (
        input  inValid, inData, coreSinkReady,
        input  coreSourceValid, coreSourceSop, coreSourceEop,
        input  coreSourceReal, coreSourceImag, coreSourceExp,
        input  gainShift, outReady,
        output inReady, coreSinkValid, coreSinkSop, coreSinkEop,
        output coreSinkReal, coreSinkImag, coreSourceReady,
        output outValid, outData, outBin, outSop, outEop, satFlag, frameError
    );

    modport master (
        output inValid, inData, coreSinkReady,
        output coreSourceValid, coreSourceSop, coreSourceEop,
        output coreSourceReal, coreSourceImag, coreSourceExp,
        output gainShift, outReady,
        input  inReady, coreSinkValid, coreSinkSop, coreSinkEop,
        input  coreSinkReal, coreSinkImag, coreSourceReady,
        input  outValid, outData, outBin, outSop, outEop, satFlag, frameError
    );

endinterface

`default_nettype wire

// File: rtl/fft_spectrum_stream_bfp_magnitude.sv
// Two-stage datapath: block-exponent normalisation, then alpha-max-beta-min
// magnitude with runtime gain and saturation.
`timescale 1ns/1ps
`default_nettype none

module bfp_magnitude
    import fft_spectrum_stream_pkg::*;
#(
    parameter int WORD_SIZE = FFT_WORD_SIZE,
    parameter int EXP_WIDTH = FFT_EXP_WIDTH,
    parameter int EXT_BITS  = FFT_EXT_BITS
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 en,
    input  wire logic [WORD_SIZE-1:0] re,
    input  wire logic [WORD_SIZE-1:0] im,
    input  wire logic [EXP_WIDTH-1:0] exp_in,
    input  wire logic [4:0]           gain,
    output logic      [WORD_SIZE-1:0] mag,
    output logic                      sat_hit
);

    localparam int EXT = WORD_SIZE + EXT_BITS;

    logic signed [EXT-1:0] re_ext, im_ext, re_shift, im_shift;
    logic signed [EXT-1:0] s1_re, s1_im;
    logic        [4:0]     s1_gain;
    logic [EXP_WIDTH-1:0]  exp_mag;

    logic [EXT-1:0]        abs_re, abs_im, max_v, min_v;
    logic [EXT:0]          sum, scaled;
    logic [WORD_SIZE-1:0]  mag_next;

    // Negative exponent scales up, positive scales down (arithmetic).
    always_comb begin
        re_ext  = {{EXT_BITS{re[WORD_SIZE-1]}}, re};
        im_ext  = {{EXT_BITS{im[WORD_SIZE-1]}}, im};
        exp_mag = exp_in[EXP_WIDTH-1] ? (~exp_in + 1'b1) : exp_in;
        if (exp_in[EXP_WIDTH-1]) begin
            re_shift = re_ext <<< exp_mag;
            im_shift = im_ext <<< exp_mag;
        end else begin
            re_shift = re_ext >>> exp_mag;
            im_shift = im_ext >>> exp_mag;
        end
    end

    always_comb begin
        abs_re   = s1_re[EXT-1] ? (~s1_re + 1'b1) : s1_re;
        abs_im   = s1_im[EXT-1] ? (~s1_im + 1'b1) : s1_im;
        max_v    = (abs_re > abs_im) ? abs_re : abs_im;
        min_v    = (abs_re > abs_im) ? abs_im : abs_re;
        sum      = {1'b0, max_v} + {3'b000, min_v[EXT-1:2]} + {4'b0000, min_v[EXT-1:3]};
        scaled   = sum >> s1_gain;
        sat_hit  = |scaled[EXT:WORD_SIZE];
        mag_next = sat_hit ? {WORD_SIZE{1'b1}} : scaled[WORD_SIZE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_re   <= '0;
            s1_im   <= '0;
            s1_gain <= '0;
            mag     <= '0;
        end else if (en) begin
            s1_re   <= re_shift;
            s1_im   <= im_shift;
            s1_gain <= gain;
            mag     <= mag_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_spectrum_stream.sv
// Streaming controller around an FFT core: frames input samples into the core
// and turns block-floating-point results into a bin-indexed magnitude stream.
`timescale 1ns/1ps
`default_nettype none

module fft_spectrum_stream
    import fft_spectrum_stream_pkg::*;
#(
    parameter int WORD_SIZE     = FFT_WORD_SIZE,
    parameter int LOG2_POINTS   = FFT_LOG2_POINTS,
    parameter int EXP_WIDTH     = FFT_EXP_WIDTH,
    parameter int EXT_BITS      = FFT_EXT_BITS,
    parameter int HALF_SPECTRUM = 1
) (
    input  wire logic inClock,
    input  wire logic resetN,
    fft_spectrum_stream_if.slave bus
);

    localparam logic [LOG2_POINTS-1:0] LAST_BIN = (HALF_SPECTRUM != 0) ?
        {1'b0, {(LOG2_POINTS-1){1'b1}}} : {LOG2_POINTS{1'b1}};

    logic [LOG2_POINTS-1:0] sample_idx;

    assign bus.inReady       = bus.coreSinkReady;
    assign bus.coreSinkValid = bus.inValid;
    assign bus.coreSinkSop   = bus.inValid & (sample_idx == '0);
    assign bus.coreSinkEop   = bus.inValid & (sample_idx == '1);
    assign bus.coreSinkReal  = bus.inData;
    assign bus.coreSinkImag  = '0;

    always_ff @(posedge inClock or negedge resetN) begin
        if (!resetN)
            sample_idx <= '0;
        else if (bus.inValid && bus.coreSinkReady)
            sample_idx <= sample_idx + 1'b1;
    end

    out_state_t             state, beat_state;
    logic [LOG2_POINTS-1:0] bin_cnt, beat_bin;
    logic [EXP_WIDTH-1:0]   exp_latch, beat_exp;
    logic [4:0]             gain_latch, beat_gain;
    logic                   enable, accept, emit, frame_error;
    logic                   s1_valid, s1_sop, s1_eop;
    logic [LOG2_POINTS-1:0] s1_bin;
    logic                   out_valid, out_sop, out_eop, sat_flag, sat_hit;
    logic [LOG2_POINTS-1:0] out_bin;

    // A sop beat in DROP must wait for the pipeline, since it will be emitted.
    assign enable              = ~out_valid | bus.outReady;
    assign bus.coreSourceReady = enable | ((state == ST_DROP) & ~bus.coreSourceSop);
    assign accept              = bus.coreSourceValid & bus.coreSourceReady;

    always_comb begin
        beat_bin   = bus.coreSourceSop ? '0 : bin_cnt;
        beat_exp   = bus.coreSourceSop ? bus.coreSourceExp : exp_latch;
        beat_gain  = bus.coreSourceSop ? bus.gainShift : gain_latch;
        emit       = accept & (bus.coreSourceSop | (state == ST_STREAM));
        beat_state = ST_STREAM;
        if (bus.coreSourceEop)
            beat_state = ST_IDLE;
        else if ((HALF_SPECTRUM != 0) && (beat_bin == LAST_BIN))
            beat_state = ST_DROP;
    end

    // bin_cnt holds the bin index of the next non-sop beat.
    always_ff @(posedge inClock or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            bin_cnt     <= '0;
            exp_latch   <= '0;
            gain_latch  <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (accept) begin
                if (bus.coreSourceSop) begin
                    frame_error <= (bin_cnt != '0);
                    exp_latch   <= bus.coreSourceExp;
                    gain_latch  <= bus.gainShift;
                    bin_cnt     <= bus.coreSourceEop ? '0 : {{(LOG2_POINTS-1){1'b0}}, 1'b1};
                    state       <= beat_state;
                end else begin
                    case (state)
                        ST_STREAM: begin
                            bin_cnt <= bus.coreSourceEop ? '0 : bin_cnt + 1'b1;
                            state   <= beat_state;
                        end
                        ST_DROP: begin
                            bin_cnt <= bus.coreSourceEop ? '0 : bin_cnt + 1'b1;
                            if (bus.coreSourceEop)
                                state <= ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge inClock or negedge resetN) begin
        if (!resetN) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_bin    <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_bin   <= '0;
            sat_flag  <= 1'b0;
        end else if (enable) begin
            s1_valid  <= emit;
            s1_sop    <= bus.coreSourceSop;
            s1_eop    <= (beat_bin == LAST_BIN);
            s1_bin    <= beat_bin;
            out_valid <= s1_valid;
            out_sop   <= s1_sop;
            out_eop   <= s1_eop;
            out_bin   <= s1_bin;
            // A new frame's first bin clears the sticky flag, then its own clamp counts.
            if (s1_valid)
                sat_flag <= (sat_flag & ~s1_sop) | sat_hit;
        end
    end

    bfp_magnitude #(
        .WORD_SIZE (WORD_SIZE),
        .EXP_WIDTH (EXP_WIDTH),
        .EXT_BITS  (EXT_BITS)
    ) u_mag (
        .clk     (inClock),
        .rst_n   (resetN),
        .en      (enable),
        .re      (bus.coreSourceReal),
        .im      (bus.coreSourceImag),
        .exp_in  (beat_exp),
        .gain    (beat_gain),
        .mag     (bus.outData),
        .sat_hit (sat_hit)
    );

    assign bus.outValid   = out_valid;
    assign bus.outBin     = out_bin;
    assign bus.outSop     = out_sop;
    assign bus.outEop     = out_eop;
    assign bus.satFlag    = sat_flag;
    assign bus.frameError = frame_error;

endmodule

`default_nettype wire

// File: tb/tb_fft_spectrum_stream.sv
// Scoreboard bench for fft_spectrum_stream with directed frames.
`timescale 1ns/1ps
`default_nettype none

module tb_fft_spectrum_stream;
    import fft_spectrum_stream_pkg::*;

    localparam int NPTS = 4096;
    localparam int HALF = 2048;

    typedef struct {
        logic [15:0] data;
        logic [11:0] bin;
        logic        sop;
        logic        eop;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_spectrum_stream_if bus ();

    fft_spectrum_stream #(.HALF_SPECTRUM(1)) dut (
        .inClock (clk),
        .resetN  (rst_n),
        .bus     (bus)
    );

    exp_t        sb[$];
    exp_t        e_pop;
    int          errors = 0;
    int          checks = 0;
    int          fe_count = 0;
    logic        stall_prev = 1'b0;
    logic [30:0] held;
    logic        rdy_stop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per transferred beat, checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev)
                check("stall_hold", {33'd0, bus.outValid, bus.outData, bus.outBin, bus.outSop, bus.outEop},
                      {33'd0, held});
            if (bus.frameError)
                fe_count++;
            if (bus.outValid && bus.outReady) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got bin %0d data %0d required none", bus.outBin, bus.outData);
                end else begin
                    e_pop = sb.pop_front();
                    check($sformatf("beat_bin%0d", e_pop.bin),
                          {34'd0, bus.outData, bus.outBin, bus.outSop, bus.outEop, bus.satFlag},
                          {34'd0, e_pop.data, e_pop.bin, e_pop.sop, e_pop.eop, e_pop.sat});
                end
            end
            stall_prev = bus.outValid & ~bus.outReady;
            held       = {bus.outValid, bus.outData, bus.outBin, bus.outSop, bus.outEop};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic src_beat(input logic [15:0] re, input logic [15:0] im, input logic [5:0] ex,
                            input logic [4:0] g, input logic sop, input logic eop);
        int t = 0;
        bus.coreSourceValid = 1'b1;
        bus.coreSourceReal  = re;
        bus.coreSourceImag  = im;
        bus.coreSourceExp   = ex;
        bus.gainShift       = g;
        bus.coreSourceSop   = sop;
        bus.coreSourceEop   = eop;
        @(negedge clk);
        while (!bus.coreSourceReady && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL src_accept_timeout: got no ready required ready");
        end
        @(posedge clk);
        #1;
        bus.coreSourceValid = 1'b0;
        bus.coreSourceSop   = 1'b0;
        bus.coreSourceEop   = 1'b0;
    endtask

    task automatic frame(input int n, input logic [15:0] re, input logic [15:0] im, input logic [5:0] ex,
                         input logic [4:0] g, input logic [15:0] expv, input logic sat);
        for (int i = 0; i < n; i++) begin
            if (i < HALF)
                sb.push_back('{expv, 12'(i), (i == 0), (i == HALF - 1), sat});
            src_beat(re, im, ex, g, (i == 0), (i == n - 1));
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 5000) begin
            t++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.inValid = 0; bus.inData = '0; bus.coreSinkReady = 1;
        bus.coreSourceValid = 0; bus.coreSourceSop = 0; bus.coreSourceEop = 0;
        bus.coreSourceReal = '0; bus.coreSourceImag = '0; bus.coreSourceExp = '0;
        bus.gainShift = '0; bus.outReady = 1;

        repeat (3) @(negedge clk);
        check("reset_out_side", {29'd0, bus.outValid, bus.outData, bus.outBin, bus.outSop, bus.outEop,
              bus.satFlag, bus.frameError, bus.coreSourceReady, bus.inReady}, 64'd3);
        check("reset_sink_side", {29'd0, bus.coreSinkValid, bus.coreSinkSop, bus.coreSinkEop,
              bus.coreSinkReal, bus.coreSinkImag}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Impulse input framing alongside a full-length core result frame.
        fork
            frame(NPTS, 16'd1000, 16'd0, 6'd0, 5'd0, 16'd1000, 1'b0);
            begin
                for (int i = 0; i < NPTS; i++) begin
                    if (i == 10) begin
                        bus.coreSinkReady = 0;
                        bus.inValid = 1;
                        @(negedge clk);
                        check("in_ready_follows", {63'd0, bus.inReady}, 64'd0);
                        @(posedge clk); #1;
                        bus.coreSinkReady = 1;
                    end
                    bus.inValid = 1;
                    bus.inData  = (i == 0) ? 16'd1000 : 16'd0;
                    @(negedge clk);
                    if (i == 0)
                        check("sink_sample0", {29'd0, bus.coreSinkValid, bus.coreSinkSop, bus.coreSinkEop,
                              bus.coreSinkReal, bus.coreSinkImag}, {29'd0, 3'b110, 16'd1000, 16'd0});
                    if (i == 1)
                        check("sink_sample1", {61'd0, bus.coreSinkValid, bus.coreSinkSop, bus.coreSinkEop}, 64'd4);
                    if (i == NPTS - 2)
                        check("sink_sample_n2", {62'd0, bus.coreSinkSop, bus.coreSinkEop}, 64'd0);
                    if (i == NPTS - 1)
                        check("sink_sample_last", {62'd0, bus.coreSinkSop, bus.coreSinkEop}, 64'd1);
                    @(posedge clk); #1;
                end
                bus.inValid = 0;
                bus.inData  = '0;
            end
        join
        drain();

        // Exponent and gain: (800+200+100)>>2 = 275, then (25+6+3)>>2 = 8.
        frame(4, 16'd100, 16'hFF9C, 6'h3D, 5'd2, 16'd275, 1'b0);
        frame(4, 16'd100, 16'hFF9C, 6'h02, 5'd2, 16'd8, 1'b0);
        // Saturation sets the sticky flag for the whole frame.
        frame(4, 16'd32767, 16'd32767, 6'h3A, 5'd0, 16'd65535, 1'b1);
        drain();

        // Backpressure: alternating, then random outReady.
        fork
            begin
                for (int c = 0; !rdy_stop; c++) begin
                    @(posedge clk); #1;
                    bus.outReady = (c < 80) ? c[0] : 1'($urandom_range(0, 1));
                end
                bus.outReady = 1;
            end
            begin
                frame(40, 16'd200, 16'd0, 6'd0, 5'd1, 16'd100, 1'b0);
                frame(40, 16'd300, 16'd400, 6'd0, 5'd0, 16'd512, 1'b0);
                drain();
                rdy_stop = 1;
            end
        join
        @(posedge clk); #1;
        check("fe_none_yet", 64'(fe_count), 64'd0);

        // Early sop at bin 37 restarts the frame.
        for (int i = 0; i < 37; i++) begin
            sb.push_back('{16'd500, 12'(i), (i == 0), 1'b0, 1'b0});
            src_beat(16'd500, 16'd0, 6'd0, 5'd0, (i == 0), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{16'd500, 12'(i), (i == 0), 1'b0, 1'b0});
            src_beat(16'd500, 16'd0, 6'd0, 5'd0, (i == 0), (i == 3));
        end
        drain();
        check("frame_error_pulse", 64'(fe_count), 64'd1);

        // Reset in the middle of an input frame and a stalled output frame.
        for (int i = 0; i < 1500; i++) begin
            bus.inValid = 1;
            bus.inData  = 16'(i);
            @(negedge clk);
            if (i == 0)
                check("sink_sop_frame2", {63'd0, bus.coreSinkSop}, 64'd1);
            @(posedge clk); #1;
        end
        bus.inValid  = 0;
        bus.outReady = 0;
        src_beat(16'd1000, 16'd0, 6'd0, 5'd0, 1'b1, 1'b0);
        src_beat(16'd1000, 16'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("stalled_before_reset", {47'd0, bus.outValid, bus.outData}, {47'd0, 1'b1, 16'd1000});
        @(posedge clk); #1;
        bus.inData = '0;
        rst_n = 0;
        @(negedge clk);
        check("midreset_out_side", {29'd0, bus.outValid, bus.outData, bus.outBin, bus.outSop, bus.outEop,
              bus.satFlag, bus.frameError, bus.coreSourceReady, bus.inReady}, 64'd3);
        check("midreset_sink_side", {29'd0, bus.coreSinkValid, bus.coreSinkSop, bus.coreSinkEop,
              bus.coreSinkReal, bus.coreSinkImag}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        bus.outReady = 1;
        @(posedge clk); #1;
        bus.inValid = 1;
        bus.inData  = 16'd7;
        @(negedge clk);
        check("sink_sop_after_reset", {47'd0, bus.coreSinkSop, bus.coreSinkReal}, {47'd0, 1'b1, 16'd7});
        @(posedge clk); #1;
        bus.inValid = 0;
        frame(2, 16'd1000, 16'd0, 6'd0, 5'd0, 16'd1000, 1'b0);
        drain();
        check("no_error_after_reset", 64'(fe_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
